// File: rtl/vedic_4bit_multi.sv
// vedic_4bit_multi: registered 4x4 unsigned multiplier on the Vedic Urdhva-Tiryagbhyam structure.
// Define VEDIC_INPUT_REG_EN to add an operand register stage (latency 2 instead of 1).
module vedic_4bit_multi (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       in_valid,
    output logic [7:0] p,
    output logic       out_valid
);

    // Returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] ha_lo;
        logic [1:0] ha_hi;
        ha_lo = half_add(x[1] & y[0], x[0] & y[1]);
        ha_hi = half_add(x[1] & y[1], ha_lo[1]);
        return {ha_hi, ha_lo[0], x[0] & y[0]};
    endfunction

    // Ripple-carry chain of full adders; the final carry is never needed since the product fits in 8 bits.
    function automatic logic [5:0] rca6(input logic [5:0] x, input logic [5:0] y);
        logic [5:0] sum;
        logic       carry;
        carry = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        return sum;
    endfunction

    logic [3:0] mult_a;
    logic [3:0] mult_b;
    logic       mult_valid;

`ifdef VEDIC_INPUT_REG_EN
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a;
            b_q     <= b;
            valid_q <= in_valid;
        end
    end

    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign mult_valid = valid_q;
`else
    assign mult_a     = a;
    assign mult_b     = b;
    assign mult_valid = in_valid;
`endif

    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [5:0] s3;
    logic [7:0] product;

    assign q0 = vedic_2x2(mult_a[1:0], mult_b[1:0]);
    assign q1 = vedic_2x2(mult_a[3:2], mult_b[1:0]);
    assign q2 = vedic_2x2(mult_a[1:0], mult_b[3:2]);
    assign q3 = vedic_2x2(mult_a[3:2], mult_b[3:2]);

    // Cross terms are weighted by 4, q3 by 16, q0 low bits pass straight through.
    assign s1      = rca6({2'b00, q1}, {2'b00, q2});
    assign s2      = rca6(s1, {4'b0000, q0[3:2]});
    assign s3      = rca6({q3, 2'b00}, s2);
    assign product = {s3, q0[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p         <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            p         <= product;
            out_valid <= mult_valid;
        end
    end

endmodule

// File: tb/tb_vedic_4bit_multi.sv
// tb_vedic_4bit_multi: directed scoreboard bench for vedic_4bit_multi in either latency build.
module tb_vedic_4bit_multi;

`ifdef VEDIC_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] p;
        logic       v;
        int         ea;
        int         eb;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [7:0] p;
    logic       out_valid;

    exp_t exp_q[$];
    int   pass_cnt;
    int   total_cnt;

    vedic_4bit_multi dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .p         (p),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0d (0x%02h), expected %0d (0x%02h)", tag, obs, obs, expv, expv);
    endtask

    // Pipeline stages hold zeros straight out of reset, so the model starts with LAT-1 zero entries.
    task automatic resetScoreboard();
        exp_t e;
        exp_q.delete();
        e.p  = 8'h00;
        e.v  = 1'b0;
        e.ea = 0;
        e.eb = 0;
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e = exp_q.pop_front();
            check($sformatf("p %0d*%0d", e.ea, e.eb), p, e.p);
            check($sformatf("out_valid %0d*%0d", e.ea, e.eb), {7'b0, out_valid}, {7'b0, e.v});
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb_in, input logic tv);
        exp_t e;
        a        = ta;
        b        = tb_in;
        in_valid = tv;
        e.ea     = int'(ta);
        e.eb     = int'(tb_in);
        e.p      = 8'(e.ea * e.eb);
        e.v      = tv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        a         = 4'hF;
        b         = 4'hF;
        in_valid  = 1'b1;

        // Let 15*15 reach p, then reset between edges and expect an immediate clear.
        #17;
        rst = 1'b1;
        #1;
        check("reset p", p, 8'h00);
        check("reset out_valid", {7'b0, out_valid}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset held p", p, 8'h00);
        check("reset held out_valid", {7'b0, out_valid}, 8'h00);
        #2;
        rst = 1'b0;
        resetScoreboard();

        $display("[TB] squares sweep");
        for (int i = 0; i < 31; i++) applyStimulus(4'(i), 4'(i), 1'b1);

        $display("[TB] corners");
        applyStimulus(4'd0, 4'd15, 1'b1);
        applyStimulus(4'd15, 4'd1, 1'b1);
        applyStimulus(4'd8, 4'd8, 1'b0);
        applyStimulus(4'd12, 4'd13, 1'b1);
        applyStimulus(4'd15, 4'd14, 1'b1);

        $display("[TB] exhaustive");
        for (int i = 0; i < 256; i++) applyStimulus(4'(i >> 4), 4'(i), (i % 3) != 0);

        $display("[TB] mid-stream reset");
        applyStimulus(4'd15, 4'd15, 1'b1);
        applyStimulus(4'd13, 4'd11, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midreset p", p, 8'h00);
        check("midreset out_valid", {7'b0, out_valid}, 8'h00);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset held p", p, 8'h00);
        check("midreset held out_valid", {7'b0, out_valid}, 8'h00);
        #2;
        rst = 1'b0;
        resetScoreboard();
        applyStimulus(4'd7, 4'd9, 1'b1);
        for (int i = 0; i < LAT; i++) applyStimulus(4'd0, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
